// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - slice-serial DCPU ADD/SUB/ADX/SBX unit with EX result.
// Optional signed-overflow output v enabled by defining ADDSUB_SIGNED_OVF_EN.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] ex_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] ex_out,
    output logic             z
`ifdef ADDSUB_SIGNED_OVF_EN
    ,
    output logic             v
`endif
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, e_q, e_d;
    logic signed [2:0]   carry_q, carry_d;
    logic [1:0]          offset_q, offset_d;
    logic [WIDTH-1:0]    res_q, res_d;
    logic [WIDTH-1:0]    q_q, q_d, ex_q, ex_d;
    logic                z_q, z_d;

    logic signed [SLICE+2:0] slice_sum;
    logic [WIDTH+SLICE-1:0]  res_cat;
    logic [WIDTH-1:0]        res_next;
    logic signed [3:0]       hi;

`ifdef ADDSUB_SIGNED_OVF_EN
    logic signed [3:0]       adj_q, adj_d;
    logic signed [3:0]       hi_s;
    logic                    v_q, v_d;
`endif

    // Subtraction is folded into the operands: b is inverted with carry-in 1, and the
    // 2^WIDTH weight lost by that inversion (plus ex_in's sign bit) is tracked in offset.
    always_comb begin
        slice_sum = $signed({3'b000, a_q[SLICE-1:0]})
                  + $signed({3'b000, b_q[SLICE-1:0]})
                  + $signed({3'b000, e_q[SLICE-1:0]})
                  + $signed({{SLICE{carry_q[2]}}, carry_q});
        res_cat   = {slice_sum[SLICE-1:0], res_q};
        res_next  = res_cat[WIDTH+SLICE-1:SLICE];
        hi        = $signed({slice_sum[SLICE+2], slice_sum[SLICE+2:SLICE]})
                  - $signed({2'b00, offset_q});

        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        e_d      = e_q;
        carry_d  = carry_q;
        offset_d = offset_q;
        res_d    = res_q;
        q_d      = q_q;
        ex_d     = ex_q;
        z_d      = z_q;
`ifdef ADDSUB_SIGNED_OVF_EN
        adj_d    = adj_q;
        v_d      = v_q;
        hi_s     = hi + adj_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    a_d      = a;
                    b_d      = op[0] ? ~b : b;
                    e_d      = op[1] ? ex_in : '0;
                    carry_d  = $signed({2'b00, op[0]});
                    offset_d = {1'b0, op[0]} + {1'b0, op[1] & ex_in[WIDTH-1]};
                    res_d    = '0;
`ifdef ADDSUB_SIGNED_OVF_EN
                    // Re-weights a and b MSBs from +2^(WIDTH-1) to -2^(WIDTH-1).
                    adj_d    = -$signed({3'b000, a[WIDTH-1]})
                             + (op[0] ? $signed({3'b000, b[WIDTH-1]})
                                      : -$signed({3'b000, b[WIDTH-1]}));
`endif
                end
            end
            RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                e_d     = e_q >> SLICE;
                carry_d = slice_sum[SLICE+2:SLICE];
                res_d   = res_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    q_d     = res_next;
                    z_d     = (res_next == '0);
                    if (hi > 4'sd0)
                        ex_d = {{(WIDTH-1){1'b0}}, 1'b1};
                    else if (hi < 4'sd0)
                        ex_d = {WIDTH{1'b1}};
                    else
                        ex_d = '0;
`ifdef ADDSUB_SIGNED_OVF_EN
                    v_d = !(((hi_s == 4'sd0) && !res_next[WIDTH-1]) ||
                            ((hi_s == -4'sd1) && res_next[WIDTH-1]));
`endif
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            e_q      <= '0;
            carry_q  <= '0;
            offset_q <= '0;
            res_q    <= '0;
            q_q      <= '0;
            ex_q     <= '0;
            z_q      <= 1'b0;
`ifdef ADDSUB_SIGNED_OVF_EN
            adj_q    <= '0;
            v_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            e_q      <= e_d;
            carry_q  <= carry_d;
            offset_q <= offset_d;
            res_q    <= res_d;
            q_q      <= q_d;
            ex_q     <= ex_d;
            z_q      <= z_d;
`ifdef ADDSUB_SIGNED_OVF_EN
            adj_q    <= adj_d;
            v_q      <= v_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q         = q_q;
    assign ex_out    = ex_q;
    assign z         = z_q;
`ifdef ADDSUB_SIGNED_OVF_EN
    assign v         = v_q;
`endif

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - scoreboard bench for addsub_serial with an integer reference model.
module tb_addsub_serial;

    localparam int W = 16;
    localparam int S = 4;
    localparam int N = W / S;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a, b, ex_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] q, ex_out;
    logic         z;
`ifdef ADDSUB_SIGNED_OVF_EN
    logic         v;
`endif

    addsub_serial #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .ex_in(ex_in), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .ex_out(ex_out), .z(z)
`ifdef ADDSUB_SIGNED_OVF_EN
        , .v(v)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] ex;
        logic         z;
        logic         v;
    } exp_t;

    int     total = 0;
    int     bad   = 0;
    longint cycle = 0;
    exp_t   exp_q[$];
    longint acc_q[$];
    logic   hold    = 1'b0;
    logic   rnd_rdy = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, want, cycle);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic [W-1:0] e);
        longint r, rs;
        exp_t   res;
        r  = longint'(x);
        rs = longint'($signed(x));
        if (o[0]) begin
            r  -= longint'(y);
            rs -= longint'($signed(y));
        end else begin
            r  += longint'(y);
            rs += longint'($signed(y));
        end
        if (o[1]) begin
            r  += longint'($signed(e));
            rs += longint'($signed(e));
        end
        res.q  = r[W-1:0];
        res.ex = (r >= (longint'(1) << W)) ? W'(1) : ((r < 0) ? {W{1'b1}} : '0);
        res.z  = (res.q == '0);
        res.v  = (rs > ((longint'(1) << (W-1)) - 1)) || (rs < -(longint'(1) << (W-1)));
        return res;
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] e, input bit track);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        op = o; a = x; b = y; ex_in = e; in_valid = 1'b1;
        @(posedge clk); #1;
        if (track) begin
            exp_q.push_back(model(o, x, y, e));
            acc_q.push_back(cycle);
        end
        in_valid = 1'b0;
        op = 2'($urandom); a = W'($urandom); b = W'($urandom); ex_in = W'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(exp_q.size()), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {W{1'b1}};
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = hold ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: latency on each out_valid rise, result comparison on each output handshake.
    initial begin
        logic   prev_ov;
        exp_t   e;
        longint c;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && !prev_ov) begin
                    if (acc_q.size() == 0)
                        check("spurious_valid", 1, 0);
                    else begin
                        c = acc_q.pop_front();
                        check("latency", 64'(cycle - c), 64'(N));
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0)
                        check("unexpected_out", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("q", 64'(q), 64'(e.q));
                        check("ex_out", 64'(ex_out), 64'(e.ex));
                        check("z", 64'(z), 64'(e.z));
`ifdef ADDSUB_SIGNED_OVF_EN
                        check("v", 64'(v), 64'(e.v));
`endif
                    end
                end
            end
            prev_ov = rst ? 1'b0 : out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; ex_in = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_q", 64'(q), 0);
        check("rst_ex_out", 64'(ex_out), 0);
        check("rst_z", 64'(z), 0);
`ifdef ADDSUB_SIGNED_OVF_EN
        check("rst_v", 64'(v), 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(2'b00, 16'hFFFF, 16'h0001, 16'h5555, 1);
        do_op(2'b01, 16'h0000, 16'h0001, 16'h0003, 1);
        do_op(2'b00, 16'h1234, 16'h0001, 16'hFFFF, 1);
        do_op(2'b10, 16'h1234, 16'h0001, 16'h0001, 1);
        do_op(2'b11, 16'h0000, 16'h0001, 16'hFFFF, 1);
        do_op(2'b10, 16'hFFFF, 16'hFFFF, 16'h7FFF, 1);
        do_op(2'b11, 16'h0000, 16'hFFFF, 16'h8000, 1);
`ifdef ADDSUB_SIGNED_OVF_EN
        do_op(2'b00, 16'h7FFF, 16'h0001, 16'h0000, 1);
`endif
        wait_drain();

        // Backpressure: result held three cycles, requests during DONE must be ignored.
        hold = 1'b1;
        do_op(2'b00, 16'h00FF, 16'h0F01, 16'h0000, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_done", 64'(out_valid), 1);
        repeat (3) begin
            in_valid = 1'b1; op = 2'b01; a = W'($urandom); b = W'($urandom);
            check("bp_q", 64'(q), 64'h1000);
            check("bp_ex_out", 64'(ex_out), 0);
            check("bp_z", 64'(z), 0);
            check("bp_in_ready", 64'(in_ready), 0);
            check("bp_out_valid", 64'(out_valid), 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        hold = 1'b0;
        wait_drain();

        // Reset during RUN cycle 2 discards the operation.
        do_op(2'b00, 16'h4321, 16'h1111, 16'h0000, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_in_ready", 64'(in_ready), 1);
        check("abort_out_valid", 64'(out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("abort_no_valid", 64'(out_valid), 0);
        end
        @(posedge clk); #1;
        do_op(2'b00, 16'h1234, 16'h0001, 16'h0000, 1);
        wait_drain();

        rnd_rdy = 1'b1;
        repeat (150) do_op(2'($urandom), pick(), pick(), pick(), 1);
        wait_drain();
        repeat (4) @(posedge clk);
        check("acc_queue_empty", 64'(acc_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
